// File: rtl/timer_bcd_chain_if.sv
// Load/control/status bundle between the keypad/load logic (master) and the
// BCD countdown timer (slave).
interface timer_bcd_chain_if #(
  parameter int NDIGITS = 4
);
  logic [4*NDIGITS-1:0] data;
  logic                 loadn;
  logic                 start;
  logic                 pause;
  logic                 tick;
  logic [4*NDIGITS-1:0] out;
  logic                 running;
  logic                 zero;
  logic                 done;
  logic [NDIGITS-1:0]   borrow;

  modport master (
    output data, loadn, start, pause, tick,
    input  out, running, zero, done, borrow
  );

  modport slave (
    input  data, loadn, start, pause, tick,
    output out, running, zero, done, borrow
  );
endinterface

// File: rtl/timer_bcd_chain.sv
// Multi-digit mixed-modulus BCD countdown timer with run/pause/done FSM.
// Define TIMER_CLAMP_EN to clamp out-of-range digits to modulus-1 on load.
//
// state  | meaning
// IDLE   | stopped; waits for start with a non-zero count
// RUN    | counting down on tick
// PAUSED | count held; start resumes
// DONE   | count reached zero; done pulses for this one cycle
module timer_bcd_chain #(
  parameter int                   NDIGITS    = 4,
  parameter logic [4*NDIGITS-1:0] DIGIT_MODS = {4'd10, 4'd10, 4'd6, 4'd10}
) (
  input  logic             clk,
  input  logic             clrn,
  timer_bcd_chain_if.slave bus
);

  localparam int W = 4 * NDIGITS;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RUN    = 2'd1,
    S_PAUSED = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   cnt_q;
  logic [W-1:0]   cnt_dec;
  logic [W-1:0]   load_val;
  logic           zero_q;
  logic [NDIGITS-1:0] borrow;
  logic           dec_en;

  // Each borrow is decoded directly from the count so there is no ripple chain.
  for (genvar i = 0; i < NDIGITS; i++) begin : g_digit
    localparam logic [3:0] MOD = DIGIT_MODS[4*i+:4];

    if (i == 0) begin : g_b0
      assign borrow[0] = bus.tick & (state_q == S_RUN);
    end else begin : g_bi
      assign borrow[i] = bus.tick & (state_q == S_RUN) & (cnt_q[4*i-1:0] == '0);
    end

    assign cnt_dec[4*i+:4] = !borrow[i]               ? cnt_q[4*i+:4] :
                             (cnt_q[4*i+:4] == 4'd0)  ? MOD - 4'd1    :
                                                        cnt_q[4*i+:4] - 4'd1;

`ifdef TIMER_CLAMP_EN
    assign load_val[4*i+:4] = (bus.data[4*i+:4] >= MOD) ? MOD - 4'd1 : bus.data[4*i+:4];
`else
    assign load_val[4*i+:4] = bus.data[4*i+:4];
`endif
  end

  assign dec_en = bus.loadn & ~bus.pause & borrow[0];

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      cnt_q  <= '0;
      zero_q <= 1'b1;
    end else if (!bus.loadn) begin
      cnt_q  <= load_val;
      zero_q <= (load_val == '0);
    end else if (dec_en) begin
      cnt_q  <= cnt_dec;
      zero_q <= (cnt_dec == '0);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Priority within each state: load, then pause, then start, then tick.
  always_comb begin
    state_d = state_q;
    if (!bus.loadn) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (!bus.pause && bus.start && !zero_q) state_d = S_RUN;
        end
        S_RUN: begin
          if (bus.pause)                          state_d = S_PAUSED;
          else if (bus.tick && cnt_dec == '0)     state_d = S_DONE;
        end
        S_PAUSED: begin
          if (!bus.pause && bus.start)            state_d = S_RUN;
        end
        S_DONE:                                   state_d = S_IDLE;
        default:                                  state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    bus.out     = cnt_q;
    bus.zero    = zero_q;
    bus.running = (state_q == S_RUN);
    bus.done    = (state_q == S_DONE);
    bus.borrow  = borrow;
  end

endmodule

// File: tb/tb_timer_bcd_chain.sv
// Directed bench for timer_bcd_chain: per-cycle compare against a digit-array
// countdown model, plus literal expectations for the documented scenarios.
module tb_timer_bcd_chain;

  localparam int          N    = 4;
  localparam logic [15:0] MODS = {4'd10, 4'd10, 4'd6, 4'd10};
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSED = 2, M_DONE = 3;

  logic clk  = 1'b0;
  logic clrn = 1'b0;

  timer_bcd_chain_if #(.NDIGITS(N)) bus ();

  timer_bcd_chain #(.NDIGITS(N), .DIGIT_MODS(MODS)) dut (
    .clk  (clk),
    .clrn (clrn),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a plain array of digit values and a state number.
  int md[N];
  int ms;

  function automatic int mod_of(input int i);
    return int'(MODS[4*i+:4]);
  endfunction

  function automatic logic [15:0] m_out();
    logic [15:0] v;
    v = '0;
    for (int i = 0; i < N; i++) v[4*i+:4] = 4'(md[i]);
    return v;
  endfunction

  function automatic bit m_allzero();
    for (int i = 0; i < N; i++) if (md[i] != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Subtract one: borrow from higher digits while lower ones are zero.
  task automatic m_decrement();
    for (int i = 0; i < N; i++) begin
      if (md[i] > 0) begin
        md[i] = md[i] - 1;
        break;
      end
      md[i] = mod_of(i) - 1;
    end
  endtask

  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      for (int i = 0; i < N; i++) md[i] = 0;
      ms = M_IDLE;
    end else if (!bus.loadn) begin
      for (int i = 0; i < N; i++) begin
        md[i] = int'(bus.data[4*i+:4]);
`ifdef TIMER_CLAMP_EN
        if (md[i] >= mod_of(i)) md[i] = mod_of(i) - 1;
`endif
      end
      ms = M_IDLE;
    end else begin
      case (ms)
        M_IDLE:   if (!bus.pause && bus.start && !m_allzero()) ms = M_RUN;
        M_RUN: begin
          if (bus.pause) ms = M_PAUSED;
          else if (bus.tick) begin
            m_decrement();
            if (m_allzero()) ms = M_DONE;
          end
        end
        M_PAUSED: if (!bus.pause && bus.start) ms = M_RUN;
        default:  ms = M_IDLE;
      endcase
    end
  end

  logic [N-1:0] exp_borrow;

  always @(negedge clk) begin
    if (clrn) begin
      for (int i = 0; i < N; i++) begin
        exp_borrow[i] = bus.tick && (ms == M_RUN);
        for (int j = 0; j < i; j++) if (md[j] != 0) exp_borrow[i] = 1'b0;
      end
      chk("cyc_out",     32'(bus.out),     32'(m_out()));
      chk("cyc_zero",    32'(bus.zero),    32'(m_allzero()));
      chk("cyc_running", 32'(bus.running), 32'(ms == M_RUN));
      chk("cyc_done",    32'(bus.done),    32'(ms == M_DONE));
      chk("cyc_borrow",  32'(bus.borrow),  32'(exp_borrow));
    end
  end

  task automatic idle_inputs();
    bus.data  = '0;
    bus.loadn = 1'b1;
    bus.start = 1'b0;
    bus.pause = 1'b0;
    bus.tick  = 1'b0;
  endtask

  task automatic step(input logic [15:0] d, input logic ld, input logic st,
                      input logic ps, input logic tk);
    bus.data  = d;
    bus.loadn = ld;
    bus.start = st;
    bus.pause = ps;
    bus.tick  = tk;
    @(posedge clk);
    #1;
    idle_inputs();
  endtask

  task automatic do_load(input logic [15:0] d); step(d, 1'b0, 1'b0, 1'b0, 1'b0); endtask
  task automatic do_start();                    step('0, 1'b1, 1'b1, 1'b0, 1'b0); endtask
  task automatic do_tick();                     step('0, 1'b1, 1'b0, 1'b0, 1'b1); endtask
  task automatic do_idle();                     step('0, 1'b1, 1'b0, 1'b0, 1'b0); endtask

  initial begin
    idle_inputs();
    #12;
    chk("rst_out",     32'(bus.out),     32'h0);
    chk("rst_zero",    32'(bus.zero),    32'h1);
    chk("rst_running", 32'(bus.running), 32'h0);
    chk("rst_done",    32'(bus.done),    32'h0);
    @(posedge clk);
    #1;
    clrn = 1'b1;

    // 1: 01:00 -> 00:59 with a full three-digit borrow
    do_load(16'h0100);
    do_start();
    bus.tick = 1'b1;
    #1;
    chk("t1_borrow", 32'(bus.borrow), 32'b0111);
    @(posedge clk);
    #1;
    idle_inputs();
    chk("t1_out",     32'(bus.out),     32'h0059);
    chk("t1_running", 32'(bus.running), 32'h1);

    // 2: run to completion
    do_load(16'h0002);
    do_start();
    do_tick();
    chk("t2_out1", 32'(bus.out), 32'h0001);
    do_tick();
    chk("t2_out0",  32'(bus.out),     32'h0000);
    chk("t2_done",  32'(bus.done),    32'h1);
    chk("t2_run",   32'(bus.running), 32'h0);
    chk("t2_zero",  32'(bus.zero),    32'h1);
    do_idle();
    chk("t2_done_gone", 32'(bus.done), 32'h0);
    do_tick();
    do_tick();
    chk("t2_hold", 32'(bus.out), 32'h0000);

    // 3: pause beats tick, resume
    do_load(16'h0010);
    do_start();
    do_tick();
    step('0, 1'b1, 1'b0, 1'b1, 1'b1);
    chk("t3_paused_out", 32'(bus.out),     32'h0009);
    chk("t3_paused_run", 32'(bus.running), 32'h0);
    do_tick();
    step('0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("t3_pause_wins", 32'(bus.running), 32'h0);
    do_start();
    do_tick();
    chk("t3_resumed", 32'(bus.out), 32'h0008);

    // 4: start with zero count stays idle
    do_load(16'h0000);
    do_start();
    do_idle();
    chk("t4_run",  32'(bus.running), 32'h0);
    chk("t4_zero", 32'(bus.zero),    32'h1);

    // idle: start & pause together keeps IDLE
    do_load(16'h0005);
    step('0, 1'b1, 1'b1, 1'b1, 1'b0);
    chk("idle_pause_wins", 32'(bus.running), 32'h0);

    // 5: async reset mid-run, then load during RUN
    do_load(16'h0131);
    do_start();
    do_tick();
    chk("t5_out", 32'(bus.out), 32'h0130);
    #2;
    clrn = 1'b0;
    #1;
    chk("t5_rst_out",  32'(bus.out),     32'h0);
    chk("t5_rst_zero", 32'(bus.zero),    32'h1);
    chk("t5_rst_run",  32'(bus.running), 32'h0);
    @(posedge clk);
    #1;
    clrn = 1'b1;
    do_load(16'h0020);
    do_start();
    do_tick();
    chk("t5_run_out", 32'(bus.out), 32'h0019);
    do_load(16'h0200);
    chk("t5_reload_out", 32'(bus.out),     32'h0200);
    chk("t5_reload_run", 32'(bus.running), 32'h0);
    do_start();
    do_tick();
    chk("t5_after", 32'(bus.out), 32'h0159);

    // 6: out-of-range digit
    do_load(16'h0075);
`ifdef TIMER_CLAMP_EN
    chk("t6_load", 32'(bus.out), 32'h0059);
`else
    chk("t6_load", 32'(bus.out), 32'h0075);
`endif
    do_start();
    do_tick();
`ifdef TIMER_CLAMP_EN
    chk("t6_tick", 32'(bus.out), 32'h0058);
`else
    chk("t6_tick", 32'(bus.out), 32'h0074);
`endif
    for (int k = 0; k < 6; k++) begin
      do_tick();
      do_idle();
    end
`ifdef TIMER_CLAMP_EN
    chk("t6_walk", 32'(bus.out), 32'h0052);
`else
    chk("t6_walk", 32'(bus.out), 32'h0068);
`endif

    // long run through a minute boundary down to done
    do_load(16'h0103);
    do_start();
    for (int k = 0; k < 63; k++) do_tick();
    chk("long_done", 32'(bus.done), 32'h1);
    do_idle();
    chk("long_out", 32'(bus.out), 32'h0000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
